// File: rtl/nw_fill_controller.sv
// nw_fill_controller: sequences the Needleman-Wunsch score-matrix fill.
// Writes the gap-penalty boundary (row 0, then column 0) and then walks the
// interior cells row-major. For each cell it reads diag/up/left from the
// single-port score RAM, runs a req/ack exchange with the cell-score unit
// and writes the returned score back to the RAM.
module nw_fill_controller #(
  parameter int N   = 128,
  parameter int SW  = 16,
  parameter int GAP = 2,
  localparam int CW = $clog2(N) + 1,
  localparam int AW = 2 * $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        i,
  output logic [CW-1:0]        j,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_rd_en,
  output logic                 ram_wr_en,
  output logic signed [SW-1:0] ram_wdata,
  input  logic signed [SW-1:0] ram_rdata,
  output logic                 calc_req,
  output logic signed [SW-1:0] calc_diag,
  output logic signed [SW-1:0] calc_up,
  output logic signed [SW-1:0] calc_left,
  input  logic                 calc_ack,
  input  logic signed [SW-1:0] calc_result,
  output logic signed [SW-1:0] final_score
);

  localparam int LG = $clog2(N);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_INIT_ROW = 4'd1;
  localparam logic [3:0] S_INIT_COL = 4'd2;
  localparam logic [3:0] S_RD_DIAG  = 4'd3;
  localparam logic [3:0] S_RD_UP    = 4'd4;
  localparam logic [3:0] S_RD_LEFT  = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_CALC     = 4'd7;
  localparam logic [3:0] S_WRITE    = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [3:0]           state_q, state_d;
  logic [CW-1:0]        i_q, i_d;
  logic [CW-1:0]        j_q, j_d;
  logic signed [SW-1:0] diag_q, diag_d;
  logic signed [SW-1:0] up_q, up_d;
  logic signed [SW-1:0] left_q, left_d;
  logic signed [SW-1:0] result_q, result_d;
  logic signed [SW-1:0] final_q, final_d;

  // Row-major RAM address of cell (ci, cj); N is a power of two so this is a concat.
  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] ci, input logic [CW-1:0] cj);
    return (AW'(ci) << LG) | AW'(cj);
  endfunction

  // Boundary score -GAP*c, wrapped to SW-bit two's complement.
  function automatic logic signed [SW-1:0] gap_score(input logic [CW-1:0] c);
    return SW'(0 - GAP * int'(c));
  endfunction

  // Next-state, coordinate stepping and operand/result capture.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    diag_d   = diag_q;
    up_d     = up_q;
    left_d   = left_q;
    result_d = result_q;
    final_d  = final_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT_ROW;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_INIT_ROW: begin
        if (j_q == LAST) begin
          state_d = S_INIT_COL;
          i_d     = ONE;
          j_d     = '0;
        end else begin
          j_d = j_q + ONE;
        end
      end
      S_INIT_COL: begin
        if (i_q == LAST) begin
          state_d = S_RD_DIAG;
          i_d     = ONE;
          j_d     = ONE;
        end else begin
          i_d = i_q + ONE;
        end
      end
      S_RD_DIAG: state_d = S_RD_UP;
      S_RD_UP: begin
        diag_d  = ram_rdata;
        state_d = S_RD_LEFT;
      end
      S_RD_LEFT: begin
        up_d    = ram_rdata;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        left_d  = ram_rdata;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (calc_ack) begin
          result_d = calc_result;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        final_d = result_q;
        if (j_q == LAST) begin
          if (i_q == LAST) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + ONE;
            j_d     = ONE;
            state_d = S_RD_DIAG;
          end
        end else begin
          j_d     = j_q + ONE;
          state_d = S_RD_DIAG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and captured scores; reset clears everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      diag_q   <= '0;
      up_q     <= '0;
      left_q   <= '0;
      result_q <= '0;
      final_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      diag_q   <= diag_d;
      up_q     <= up_d;
      left_q   <= left_d;
      result_q <= result_d;
      final_q  <= final_d;
    end
  end

  // Strobes, address and write data decoded from state and counters.
  // Strobes are masked by rst so an aborting cycle never touches the RAM.
  always_comb begin
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    calc_req  = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_INIT_ROW: begin
        ram_wr_en = ~rst;
        ram_addr  = addr_of(i_q, j_q);
        ram_wdata = gap_score(j_q);
      end
      S_INIT_COL: begin
        ram_wr_en = ~rst;
        ram_addr  = addr_of(i_q, j_q);
        ram_wdata = gap_score(i_q);
      end
      S_RD_DIAG: begin
        ram_rd_en = ~rst;
        ram_addr  = addr_of(i_q - ONE, j_q - ONE);
      end
      S_RD_UP: begin
        ram_rd_en = ~rst;
        ram_addr  = addr_of(i_q - ONE, j_q);
      end
      S_RD_LEFT: begin
        ram_rd_en = ~rst;
        ram_addr  = addr_of(i_q, j_q - ONE);
      end
      S_CALC: calc_req = 1'b1;
      S_WRITE: begin
        ram_wr_en = ~rst;
        ram_addr  = addr_of(i_q, j_q);
        ram_wdata = result_q;
      end
      default: ;
    endcase
  end

  assign i           = i_q;
  assign j           = j_q;
  assign calc_diag   = diag_q;
  assign calc_up     = up_q;
  assign calc_left   = left_q;
  assign final_score = final_q;

endmodule
